// File: rtl/fpu_pkg.sv
// Shared FPU definitions: exception flag positions, flag vector type,
// canonical quiet NaN and round-mode encoding.
// No logic; constants and types only, imported by the fmul issue stage files.
package fpu_pkg;

  // Bit positions inside a 5-bit exception flag vector.
  localparam int FLAG_INVALID   = 4;
  localparam int FLAG_DIVZERO   = 3;
  localparam int FLAG_OVERFLOW  = 2;
  localparam int FLAG_UNDERFLOW = 1;
  localparam int FLAG_INEXACT   = 0;

  typedef logic [4:0] flags_t;

  // Canonical single-precision quiet NaN.
  localparam logic [31:0] QNAN32 = 32'h7FC0_0000;

  // Round-mode encoding carried with each request.
  typedef enum logic {
    RM_TRUNC   = 1'b0,
    RM_NEAREST = 1'b1
  } rm_e;

endpackage

// File: rtl/fmul_issue_if.sv
// Request / multiplier / result bundle of the fmul issue stage.
// No latency of its own; carries valid/ready on the request and result sides.
// Ports: in_* request (valid/ready), mul_* to and from fmul, out_* result
// (valid/ready), fflags/fflags_clr sticky exception flags, busy status.
// slave is the stage's view, master is the driving environment's view.
interface fmul_issue_if #(
  parameter int width = 32,
  parameter int tagw  = 4
);
  import fpu_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [width-1:0]  in_a;
  logic [width-1:0]  in_b;
  logic              in_rm;
  logic [tagw-1:0]   in_tag;

  logic [width-1:0]  mul_a;
  logic [width-1:0]  mul_b;
  logic              mul_rm;
  logic [width-1:0]  mul_r;
  flags_t            mul_flags;

  logic              out_valid;
  logic              out_ready;
  logic [width-1:0]  out_r;
  flags_t            out_flags;
  logic [tagw-1:0]   out_tag;

  flags_t            fflags;
  logic              fflags_clr;
  logic              busy;

  modport slave (
    input  in_valid, in_a, in_b, in_rm, in_tag,
    input  mul_r, mul_flags,
    input  out_ready, fflags_clr,
    output in_ready,
    output mul_a, mul_b, mul_rm,
    output out_valid, out_r, out_flags, out_tag,
    output fflags, busy
  );

  modport master (
    output in_valid, in_a, in_b, in_rm, in_tag,
    output mul_r, mul_flags,
    output out_ready, fflags_clr,
    input  in_ready,
    input  mul_a, mul_b, mul_rm,
    input  out_valid, out_r, out_flags, out_tag,
    input  fflags, busy
  );

endinterface

// File: rtl/fmul_issue_fifo.sv
// Circular result FIFO with occupancy count; head is presented combinationally.
// Latency: an entry pushed at edge N is at the head from the cycle after N.
// Backpressure: caller guarantees no push when full; pop on empty is ignored.
// Ports: clk, rst_n; push/push_dat write side; pop read side; head (zero
// when empty) and count status.
module fmul_issue_fifo #(
  parameter int dw    = 8,
  parameter int depth = 3
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [dw-1:0]              push_dat,
  input  logic                       pop,
  output logic [dw-1:0]              head,
  output logic [$clog2(depth+1)-1:0] count
);

  localparam int pw = (depth > 1) ? $clog2(depth) : 1;
  localparam int cw = $clog2(depth + 1);

  logic [dw-1:0] mem [depth];
  logic [pw-1:0] wr_ptr;
  logic [pw-1:0] rd_ptr;
  logic [cw-1:0] cnt;
  logic          pop_ok;

  // Pointers wrap at depth, which need not be a power of two.
  function automatic logic [pw-1:0] wrap_inc(input logic [pw-1:0] p);
    return (p == pw'(depth - 1)) ? '0 : p + 1'b1;
  endfunction

  assign pop_ok = pop & (cnt != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push)   wr_ptr <= wrap_inc(wr_ptr);
      if (pop_ok) rd_ptr <= wrap_inc(rd_ptr);
      unique case ({push, pop_ok})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage needs no reset: an entry is only visible while counted.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_dat;
  end

  assign head  = (cnt != '0) ? mem[rd_ptr] : '0;
  assign count = cnt;

endmodule

// File: rtl/fmul_issue.sv
// Issue/retire stage around the combinational fmul: registers operands (S1),
// captures the result into an in-order FIFO, keeps sticky fflags.
// Latency 2 cycles accept-to-out_valid; in_ready is a registered credit check
// (S1 + FIFO occupancy < depth) with no path from out_ready.
// Ports: clk, rst_n (async, active low); io.slave carries request, fmul
// operand/result, result output, fflags/fflags_clr and busy.
module fmul_issue
  import fpu_pkg::*;
#(
  parameter int exp   = 8,
  parameter int frac  = 23,
  parameter int width = exp + frac + 1,
  parameter int tagw  = 4,
  parameter int depth = 3
) (
  input logic         clk,
  input logic         rst_n,
  fmul_issue_if.slave io
);

  localparam int cw = $clog2(depth + 1);

  typedef struct packed {
    logic [width-1:0] r;
    flags_t           flags;
    logic [tagw-1:0]  tag;
  } entry_t;

  logic             s1_valid;
  logic [width-1:0] s1_a;
  logic [width-1:0] s1_b;
  logic             s1_rm;
  logic [tagw-1:0]  s1_tag;

  logic [cw-1:0]    count;
  logic [cw:0]      occ;
  logic             accept;
  logic             pop;
  entry_t           push_dat;
  entry_t           head;
  flags_t           fflags_q;

  // Every op in S1 retires next edge, so S1 counts against FIFO room.
  assign occ         = {1'b0, count} + {{cw{1'b0}}, s1_valid};
  assign io.in_ready = (occ < (cw + 1)'(depth));
  assign accept      = io.in_valid & io.in_ready;

  // Operand registers only load on accept so fmul inputs stay quiet when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_rm    <= 1'b0;
      s1_tag   <= '0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_a   <= io.in_a;
        s1_b   <= io.in_b;
        s1_rm  <= io.in_rm;
        s1_tag <= io.in_tag;
      end
    end
  end

  assign io.mul_a  = s1_a;
  assign io.mul_b  = s1_b;
  assign io.mul_rm = s1_rm;

  always_comb begin
    push_dat       = '0;
    push_dat.r     = io.mul_r;
    push_dat.flags = io.mul_flags;
    push_dat.tag   = s1_tag;
  end

  fmul_issue_fifo #(
    .dw    ($bits(entry_t)),
    .depth (depth)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (s1_valid),
    .push_dat (push_dat),
    .pop      (pop),
    .head     (head),
    .count    (count)
  );

  assign io.out_valid = (count != '0);
  assign pop          = io.out_valid & io.out_ready;
  assign io.out_r     = head.r;
  assign io.out_flags = head.flags;
  assign io.out_tag   = head.tag;

  // Clear acts on the old value, so a clear coinciding with a pop keeps
  // exactly the popped flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fflags_q <= '0;
    end else begin
      fflags_q <= (io.fflags_clr ? '0 : fflags_q) | (pop ? head.flags : '0);
    end
  end

  assign io.fflags = fflags_q;
  assign io.busy   = s1_valid | (count != '0);

endmodule

// File: tb/tb_fmul_issue.sv
// Bench for fmul_issue with a behavioural fmul alongside and a result scoreboard.
// Drives inputs just after the rising edge, samples on the falling edge.
// Expected results are queued at accept and compared when the DUT pops.
module tb_fmul_issue;
  import fpu_pkg::*;

  localparam int W     = 32;
  localparam int TW    = 4;
  localparam int DEPTH = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fmul_issue_if #(.width(W), .tagw(TW)) bus ();

  fmul_issue #(
    .exp(8), .frac(23), .width(W), .tagw(TW), .depth(DEPTH)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (bus.slave)
  );

  // Behavioural single-precision multiply; subnormals flush to zero.
  function automatic logic [36:0] fmul_model(input logic [31:0] a, input logic [31:0] b,
                                             input logic rm);
    logic s, a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, g, st;
    int ea, eb, e;
    logic [47:0] p;
    logic [23:0] m;
    logic [31:0] r;
    logic [4:0] f;
    f = '0; r = '0; m = '0;
    s = a[31] ^ b[31];
    ea = int'(a[30:23]); eb = int'(b[30:23]);
    a_nan = (ea == 255) && (a[22:0] != 0);
    b_nan = (eb == 255) && (b[22:0] != 0);
    a_inf = (ea == 255) && (a[22:0] == 0);
    b_inf = (eb == 255) && (b[22:0] == 0);
    a_zero = (ea == 0);
    b_zero = (eb == 0);
    if (a_nan || b_nan) begin
      r = QNAN32;
      if ((a_nan && !a[22]) || (b_nan && !b[22])) f[FLAG_INVALID] = 1'b1;
    end else if ((a_inf && b_zero) || (b_inf && a_zero)) begin
      r = QNAN32;
      f[FLAG_INVALID] = 1'b1;
    end else if (a_inf || b_inf) begin
      r = {s, 8'hFF, 23'h0};
    end else if (a_zero || b_zero) begin
      r = {s, 31'h0};
    end else begin
      p = {24'h0, 1'b1, a[22:0]} * {24'h0, 1'b1, b[22:0]};
      if (p[47]) begin
        m = p[47:24]; g = p[23]; st = |p[22:0]; e = ea + eb - 126;
      end else begin
        m = p[46:23]; g = p[22]; st = |p[21:0]; e = ea + eb - 127;
      end
      if (g || st) f[FLAG_INEXACT] = 1'b1;
      if (rm && g && (st || m[0])) begin
        m = m + 24'd1;
        if (m == 24'd0) begin
          m = 24'h800000;
          e = e + 1;
        end
      end
      if (e >= 255) begin
        r = rm ? {s, 8'hFF, 23'h0} : {s, 8'hFE, 23'h7FFFFF};
        f[FLAG_OVERFLOW] = 1'b1;
        f[FLAG_INEXACT]  = 1'b1;
      end else if (e <= 0) begin
        r = {s, 31'h0};
        f[FLAG_UNDERFLOW] = 1'b1;
        f[FLAG_INEXACT]   = 1'b1;
      end else begin
        r = {s, e[7:0], m[22:0]};
      end
    end
    return {r, f};
  endfunction

  logic [36:0] mres;
  always_comb mres = fmul_model(bus.mul_a, bus.mul_b, bus.mul_rm);
  assign bus.mul_r     = mres[36:5];
  assign bus.mul_flags = mres[4:0];

  typedef struct {
    logic [31:0] r;
    logic [4:0]  f;
    logic [3:0]  tag;
  } exp_t;
  exp_t sbq[$];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int last_pop = -10;
  int run      = 0;
  int max_run  = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, want, $time);
    end
  endtask

  // Result monitor: scoreboard compare on every pop, plus occupancy bound.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.out_valid && bus.out_ready) begin
        if (sbq.size() == 0) begin
          check("unexpected_out", {60'h0, bus.out_tag}, 64'hDEAD);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          check("out_r", {32'h0, bus.out_r}, {32'h0, e.r});
          check("out_flags", {59'h0, bus.out_flags}, {59'h0, e.f});
          check("out_tag", {60'h0, bus.out_tag}, {60'h0, e.tag});
        end
        if (cyc == last_pop + 1) run++;
        else run = 1;
        if (run > max_run) max_run = run;
        last_pop = cyc;
      end
      if (dut.u_fifo.count > DEPTH)
        check("fifo_count", 64'(dut.u_fifo.count), 64'(DEPTH));
    end
  end

  // Presents a request and waits for acceptance; in_valid stays high on return.
  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic rm,
                      input logic [3:0] tag, output int stalls);
    logic [36:0] m;
    stalls = 0;
    bus.in_valid = 1'b1;
    bus.in_a = a; bus.in_b = b; bus.in_rm = rm; bus.in_tag = tag;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        m = fmul_model(a, b, rm);
        sbq.push_back('{r: m[36:5], f: m[4:0], tag: tag});
        @(posedge clk); #1;
        return;
      end
      stalls++;
    end
    check("send_timeout", 64'd0, 64'd1);
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (sbq.size() == 0 && !bus.busy) begin
        @(posedge clk); #1;
        return;
      end
    end
    check("drain_timeout", 64'd0, 64'd1);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int st, tot, acc;
    logic [3:0] t;
    bus.in_valid = 0; bus.in_a = 0; bus.in_b = 0; bus.in_rm = 0; bus.in_tag = 0;
    bus.out_ready = 0; bus.fflags_clr = 0;

    // Reset state
    @(negedge clk);
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_fflags", 64'(bus.fflags), 64'd0);
    check("rst_out_r", 64'(bus.out_r), 64'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();

    // Single op with latency check
    bus.out_ready = 1'b1;
    send(32'h3FC00000, 32'h40000000, 1'b1, 4'd5, st);
    bus.in_valid = 1'b0;
    check("single_exp_r", {32'h0, sbq[0].r}, 64'h40400000);
    @(negedge clk);
    check("single_lat1_valid", 64'(bus.out_valid), 64'd0);
    @(negedge clk);
    check("single_lat2_valid", 64'(bus.out_valid), 64'd1);
    check("single_out_r", 64'(bus.out_r), 64'h40400000);
    check("single_out_tag", 64'(bus.out_tag), 64'd5);
    drain();
    check("single_fflags", 64'(bus.fflags), 64'd0);
    check("idle_out_tag_zero", 64'(bus.out_tag), 64'd0);

    // Streaming 8 back-to-back
    max_run = 0; tot = 0;
    for (int k = 0; k < 8; k++) begin
      send(32'h3F800000 + (k << 20), 32'h40000000, 1'b1, 4'(k), st);
      tot += st;
    end
    bus.in_valid = 1'b0;
    drain();
    check("stream_stalls", 64'(tot), 64'd0);
    check("stream_run", 64'(max_run), 64'd8);

    // Backpressure: exactly DEPTH accepts
    bus.out_ready = 1'b0;
    acc = 0; t = 4'd8;
    bus.in_valid = 1'b1; bus.in_rm = 1'b1;
    bus.in_a = 32'h40000000 + (32'(t) << 19); bus.in_b = 32'h3F800000; bus.in_tag = t;
    for (int i = 0; i < 8; i++) begin
      logic [36:0] m;
      logic took;
      @(negedge clk);
      took = bus.in_ready;
      if (took) begin
        m = fmul_model(bus.in_a, bus.in_b, bus.in_rm);
        sbq.push_back('{r: m[36:5], f: m[4:0], tag: bus.in_tag});
        acc++;
      end
      tick();
      if (took) begin
        t = t + 4'd1;
        bus.in_a = 32'h40000000 + (32'(t) << 19); bus.in_tag = t;
      end
    end
    check("bp_accepts", 64'(acc), 64'(DEPTH));
    check("bp_in_ready_low", 64'(bus.in_ready), 64'd0);
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("bp_ready_pop_cycle", 64'(bus.in_ready), 64'd0);
    @(negedge clk);
    check("bp_ready_after_pop", 64'(bus.in_ready), 64'd1);
    drain();

    // Wrap-around with random backpressure
    fork
      begin
        for (int k = 0; k < 10; k++)
          send(32'h3F800000 + (k << 19), 32'h40400000, k[0], 4'(k + 3), st);
        bus.in_valid = 1'b0;
      end
      begin
        repeat (60) begin
          tick();
          bus.out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    bus.out_ready = 1'b1;
    drain();

    // Exceptions and sticky flags
    bus.fflags_clr = 1'b1; tick(); bus.fflags_clr = 1'b0;
    send(32'h7F800000, 32'h00000000, 1'b1, 4'd1, st);
    send(32'h7F000000, 32'h7F000000, 1'b1, 4'd2, st);
    bus.in_valid = 1'b0;
    check("exc_nan_r", {32'h0, sbq[0].r}, 64'h7FC00000);
    check("exc_nan_f", {59'h0, sbq[0].f}, 64'b10000);
    check("exc_ovf_r", {32'h0, sbq[1].r}, 64'h7F800000);
    check("exc_ovf_f", {59'h0, sbq[1].f}, 64'b00101);
    drain();
    check("sticky_fflags", 64'(bus.fflags), 64'b10101);

    // Clear coinciding with pop
    bus.out_ready = 1'b0;
    send(32'h7F000000, 32'h7F000000, 1'b1, 4'd3, st);
    bus.in_valid = 1'b0;
    for (int i = 0; i < 10 && !bus.out_valid; i++) tick();
    check("clr_pop_valid", 64'(bus.out_valid), 64'd1);
    bus.out_ready = 1'b1; bus.fflags_clr = 1'b1;
    tick();
    bus.fflags_clr = 1'b0;
    @(negedge clk);
    check("clr_on_pop_fflags", 64'(bus.fflags), 64'b00101);
    tick();
    bus.fflags_clr = 1'b1; tick(); bus.fflags_clr = 1'b0;
    @(negedge clk);
    check("clr_no_pop_fflags", 64'(bus.fflags), 64'd0);
    tick();

    // Reset mid-operation
    send(32'h7F000000, 32'h7F000000, 1'b0, 4'd4, st);
    bus.in_valid = 1'b0;
    drain();
    check("pre_rst_fflags", 64'(bus.fflags), 64'b00101);
    bus.out_ready = 1'b0;
    send(32'h3FC00000, 32'h40000000, 1'b1, 4'd9, st);
    send(32'h40000000, 32'h40000000, 1'b1, 4'd10, st);
    bus.in_valid = 1'b0;
    check("pre_rst_busy", 64'(bus.busy), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("mid_rst_busy", 64'(bus.busy), 64'd0);
    check("mid_rst_fflags", 64'(bus.fflags), 64'd0);
    check("mid_rst_in_ready", 64'(bus.in_ready), 64'd1);
    check("mid_rst_mul_a", 64'(bus.mul_a), 64'd0);
    sbq.delete();
    tick(); tick();
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("post_rst_out_valid", 64'(bus.out_valid), 64'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
